// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle types and ALU decode helpers for the
// five-stage RV32 pipeline control unit.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_DIV    = 4'b1010,
    ALU_REM    = 4'b1011,
    ALU_MUL    = 4'b1100,
    ALU_MULH   = 4'b1101,
    ALU_MULHSU = 4'b1110,
    ALU_MULHU  = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } alu_src_a_e;

  // Full control bundle produced in Decode and held in ID/EX.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    alu_src_a_e  alusrca;
    logic        alusrcb;
    logic        memwrite;
    result_src_e resultsrc;
    logic        branch;
    logic [2:0]  branchop;
    logic        jump;
    logic        jumpreg;
    alu_op_e     alucontrol;
    logic [2:0]  memsize;
  } ctrl_bundle_t;

  // Subset still needed once the instruction has left Execute.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic [2:0]  memsize;
    result_src_e resultsrc;
  } mem_bundle_t;

  // Subset still needed in Writeback.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    result_src_e resultsrc;
  } wb_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  localparam mem_bundle_t  MEM_BUBBLE  = '0;
  localparam wb_bundle_t   WB_BUBBLE   = '0;

  // Base integer ALU op from funct3; alt selects sub/sra.
  function automatic alu_op_e alu_base(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // RV32M op: multiplies keep funct3[1:0], divide/remainder split on funct3[1].
  function automatic alu_op_e alu_muldiv(input logic [2:0] funct3);
    alu_op_e op;
    if (funct3[2]) begin
      if (funct3[1]) begin
        op = ALU_REM;
      end else begin
        op = ALU_DIV;
      end
    end else begin
      op = alu_op_e'({2'b11, funct3[1:0]});
    end
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Decode-stage control: full opcode/funct3/funct7 decode into
// a control bundle, immediate-format select and illegal-encoding detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]  instr,
  input  logic         valid,
  output ctrl_bundle_t ctrl,
  output imm_src_e     immsrc,
  output logic         illegal
);

  logic [6:0]   opcode_s;
  logic [2:0]   funct3_s;
  logic [6:0]   funct7_s;
  logic         is_imm_s;
  logic         alt_s;
  logic         bad_s;
  ctrl_bundle_t dec_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  // Raw decode of the instruction fields, independent of valid.
  always_comb begin
    dec_s    = CTRL_BUBBLE;
    immsrc   = IMM_I;
    bad_s    = 1'b0;
    is_imm_s = (opcode_s == OP_IALU);
    alt_s    = funct7_s[5] && (!is_imm_s || (funct3_s == 3'b101));
    case (opcode_s)
      OP_LOAD: begin
        dec_s.regwrite  = 1'b1;
        dec_s.alusrcb   = 1'b1;
        dec_s.resultsrc = RES_MEM;
        dec_s.memsize   = funct3_s;
        immsrc          = IMM_I;
        bad_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
      end
      OP_STORE: begin
        dec_s.alusrcb  = 1'b1;
        dec_s.memwrite = 1'b1;
        dec_s.memsize  = funct3_s;
        immsrc         = IMM_S;
        bad_s = funct3_s[2] || (funct3_s == 3'b011);
      end
      OP_RTYPE, OP_IALU: begin
        dec_s.regwrite   = 1'b1;
        dec_s.alusrcb    = is_imm_s;
        dec_s.alucontrol = alu_base(funct3_s, alt_s);
        immsrc           = IMM_I;
        if (!is_imm_s && (funct7_s == 7'b0000001)) begin
          dec_s.alucontrol = alu_muldiv(funct3_s);
          bad_s = !EN_M;
        end else if (!is_imm_s || (funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          // funct7 only matters for register ops and immediate shifts
          bad_s = !((funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) &&
                     ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
        end else begin
          bad_s = 1'b0;
        end
      end
      OP_BRANCH: begin
        dec_s.branch   = 1'b1;
        dec_s.branchop = funct3_s;
        immsrc         = IMM_B;
        case (funct3_s[2:1])
          2'b00:   dec_s.alucontrol = ALU_SUB;
          2'b10:   dec_s.alucontrol = ALU_SLT;
          2'b11:   dec_s.alucontrol = ALU_SLTU;
          default: bad_s = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec_s.regwrite  = 1'b1;
        dec_s.resultsrc = RES_PC4;
        dec_s.jump      = 1'b1;
        immsrc          = IMM_J;
      end
      OP_JALR: begin
        dec_s.regwrite  = 1'b1;
        dec_s.alusrcb   = 1'b1;
        dec_s.resultsrc = RES_PC4;
        dec_s.jump      = 1'b1;
        dec_s.jumpreg   = 1'b1;
        immsrc          = IMM_I;
        bad_s = (funct3_s != 3'b000);
      end
      OP_LUI: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrca  = SRCA_ZERO;
        dec_s.alusrcb  = 1'b1;
        immsrc         = IMM_U;
      end
      OP_AUIPC: begin
        dec_s.regwrite = 1'b1;
        dec_s.alusrca  = SRCA_PC;
        dec_s.alusrcb  = 1'b1;
        immsrc         = IMM_U;
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
    // all-zero word is a common "fell into empty memory" symptom
    if (instr == 32'h0000_0000) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end

  // Only valid, legal instructions leave Decode as non-bubbles.
  always_comb begin
    illegal = valid && bad_s;
    if (valid && !bad_s) begin
      ctrl       = dec_s;
      ctrl.valid = 1'b1;
    end else begin
      ctrl = CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// Pipeline control unit: decodes in D and carries the control bundle through
// ID/EX, EX/MEM and MEM/WB with stall/flush bubble insertion.
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter bit EN_M            = 1'b0,
  parameter bit EN_ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [2:0]  immsrc_d,
  output logic        illegal_d,
  output logic        valid_e,
  output logic        valid_m,
  output logic        valid_w,
  output logic [3:0]  alucontrol_e,
  output logic [1:0]  alusrca_e,
  output logic        alusrcb_e,
  output logic        branch_e,
  output logic [2:0]  branchop_e,
  output logic        jump_e,
  output logic        jumpreg_e,
  output logic        memwrite_m,
  output logic [2:0]  memsize_m,
  output logic        regwrite_m,
  output logic [1:0]  resultsrc_w,
  output logic        regwrite_w
);

  ctrl_bundle_t dec_s;
  imm_src_e     immsrc_s;
  logic         illegal_s;

  ctrl_bundle_t idex_d,  idex_q;
  mem_bundle_t  exmem_d, exmem_q;
  wb_bundle_t   memwb_d, memwb_q;

  ctrl_decode #(
    .EN_M(EN_M)
  ) u_decode (
    .instr   (instr_d),
    .valid   (valid_d),
    .ctrl    (dec_s),
    .immsrc  (immsrc_s),
    .illegal (illegal_s)
  );

  assign immsrc_d = immsrc_s;

  // Report illegal encodings only when trapping is enabled.
  always_comb begin
    if (EN_ILLEGAL_TRAP) begin
      illegal_d = illegal_s;
    end else begin
      illegal_d = 1'b0;
    end
  end

  // Next-state for each pipeline register: flush beats stall; a stalled E
  // sends a bubble forward so the held instruction never reaches M twice.
  always_comb begin
    if (flush_e) begin
      idex_d = CTRL_BUBBLE;
    end else if (stall_e) begin
      idex_d = idex_q;
    end else begin
      idex_d = dec_s;
    end

    if (stall_e && !flush_e) begin
      exmem_d = MEM_BUBBLE;
    end else begin
      exmem_d.valid     = idex_q.valid;
      exmem_d.regwrite  = idex_q.regwrite;
      exmem_d.memwrite  = idex_q.memwrite;
      exmem_d.memsize   = idex_q.memsize;
      exmem_d.resultsrc = idex_q.resultsrc;
    end

    memwb_d.valid     = exmem_q.valid;
    memwb_d.regwrite  = exmem_q.regwrite;
    memwb_d.resultsrc = exmem_q.resultsrc;
  end

  // Pipeline registers; reset drops every in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= CTRL_BUBBLE;
      exmem_q <= MEM_BUBBLE;
      memwb_q <= WB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign valid_e      = idex_q.valid;
  assign alucontrol_e = idex_q.alucontrol;
  assign alusrca_e    = idex_q.alusrca;
  assign alusrcb_e    = idex_q.alusrcb;
  assign branch_e     = idex_q.branch & idex_q.valid;
  assign branchop_e   = idex_q.branchop;
  assign jump_e       = idex_q.jump & idex_q.valid;
  assign jumpreg_e    = idex_q.jumpreg;

  assign valid_m      = exmem_q.valid;
  assign memwrite_m   = exmem_q.memwrite & exmem_q.valid;
  assign memsize_m    = exmem_q.memsize;
  assign regwrite_m   = exmem_q.regwrite & exmem_q.valid;

  assign valid_w      = memwb_q.valid;
  assign resultsrc_w  = memwb_q.resultsrc;
  assign regwrite_w   = memwb_q.regwrite & memwb_q.valid;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Self-checking bench: two instances (EN_M=0/trap on, EN_M=1/trap off) driven
// in lockstep and compared against a mask/match instruction table model.
module tb_pipelined_ctrl_unit;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic       alusrcb;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic [2:0] branchop;
    logic       jump;
    logic       jumpreg;
    logic [3:0] alucontrol;
    logic [2:0] memsize;
    logic       dc_imm;
    logic       dc_src;
  } exp_t;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic        needs_m;
    exp_t        e;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d, stall_e, flush_e;

  logic [2:0] immsrc_d[2];
  logic       illegal_d[2], valid_e[2], valid_m[2], valid_w[2];
  logic [3:0] alucontrol_e[2];
  logic [1:0] alusrca_e[2];
  logic       alusrcb_e[2], branch_e[2], jump_e[2], jumpreg_e[2];
  logic [2:0] branchop_e[2], memsize_m[2];
  logic       memwrite_m[2], regwrite_m[2], regwrite_w[2];
  logic [1:0] resultsrc_w[2];

  ent_t tbl[$];
  exp_t st_e[2], st_m[2], st_w[2];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rw_pulses;

  logic [6:0] ops[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  localparam logic [31:0] I_LW    = 32'h0001_2083;
  localparam logic [31:0] I_ADD   = 32'h0010_81B3;
  localparam logic [31:0] I_JALR  = 32'h0000_8067;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_BEQ   = 32'h0020_8063;
  localparam logic [31:0] I_MUL   = 32'h0231_00B3;
  localparam logic [31:0] I_AUIPC = 32'h0000_1297;
  localparam logic [31:0] I_LUI   = 32'h0000_12B7;
  localparam logic [31:0] I_BLTU  = 32'h0020_E063;

  pipelined_ctrl_unit #(.EN_M(1'b0), .EN_ILLEGAL_TRAP(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .immsrc_d(immsrc_d[0]), .illegal_d(illegal_d[0]),
    .valid_e(valid_e[0]), .valid_m(valid_m[0]), .valid_w(valid_w[0]),
    .alucontrol_e(alucontrol_e[0]), .alusrca_e(alusrca_e[0]), .alusrcb_e(alusrcb_e[0]),
    .branch_e(branch_e[0]), .branchop_e(branchop_e[0]), .jump_e(jump_e[0]),
    .jumpreg_e(jumpreg_e[0]), .memwrite_m(memwrite_m[0]), .memsize_m(memsize_m[0]),
    .regwrite_m(regwrite_m[0]), .resultsrc_w(resultsrc_w[0]), .regwrite_w(regwrite_w[0])
  );

  pipelined_ctrl_unit #(.EN_M(1'b1), .EN_ILLEGAL_TRAP(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .immsrc_d(immsrc_d[1]), .illegal_d(illegal_d[1]),
    .valid_e(valid_e[1]), .valid_m(valid_m[1]), .valid_w(valid_w[1]),
    .alucontrol_e(alucontrol_e[1]), .alusrca_e(alusrca_e[1]), .alusrcb_e(alusrcb_e[1]),
    .branch_e(branch_e[1]), .branchop_e(branchop_e[1]), .jump_e(jump_e[1]),
    .jumpreg_e(jumpreg_e[1]), .memwrite_m(memwrite_m[1]), .memsize_m(memsize_m[1]),
    .regwrite_m(regwrite_m[1]), .resultsrc_w(resultsrc_w[1]), .regwrite_w(regwrite_w[1])
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input bit m,
                     input logic rw, input logic [2:0] imm, input logic [1:0] sa,
                     input logic sb, input logic mw, input logic [1:0] rs,
                     input logic br, input logic jp, input logic jr, input logic [3:0] alu);
    ent_t t;
    t = '0;
    t.mask = mask; t.match = match; t.needs_m = m;
    t.e.regwrite = rw; t.e.immsrc = imm; t.e.alusrca = sa; t.e.alusrcb = sb;
    t.e.memwrite = mw; t.e.resultsrc = rs; t.e.branch = br; t.e.jump = jp;
    t.e.jumpreg = jr; t.e.alucontrol = alu;
    if (br) t.e.branchop = match[14:12];
    if (mw || (rs == 2'b01)) t.e.memsize = match[14:12];
    t.e.dc_imm = (match[6:0] == 7'h33);
    t.e.dc_src = (match[6:0] == 7'h6F);
    tbl.push_back(t);
  endtask

  // Legal RV32I(+M) instruction list in mask/match form with expected controls.
  task automatic build_table();
    logic [2:0] ld_f3[5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0] r_f7[10]  = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0] r_f3[10]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [3:0] r_alu[10] = '{4'd0, 4'd1, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd9, 4'd3, 4'd2};
    logic [2:0] b_f3[6]   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [3:0] b_alu[6]  = '{4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6};
    logic [3:0] malu;
    for (int i = 0; i < 5; i++)
      add(32'h0000_707F, enc(7'h00, ld_f3[i], 7'h03), 0, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++)
      add(32'h0000_707F, enc(7'h00, 3'(i), 7'h23), 0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      add(32'hFE00_707F, enc(r_f7[i], r_f3[i], 7'h33), 0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, r_alu[i]);
      if (i != 1) begin
        if ((r_f3[i] == 3'd1) || (r_f3[i] == 3'd5))
          add(32'hFE00_707F, enc(r_f7[i], r_f3[i], 7'h13), 0, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, r_alu[i]);
        else
          add(32'h0000_707F, enc(7'h00, r_f3[i], 7'h13), 0, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, r_alu[i]);
      end
    end
    for (int f = 0; f < 8; f++) begin
      malu = (f < 4) ? 4'(12 + f) : ((f < 6) ? 4'd10 : 4'd11);
      add(32'hFE00_707F, enc(7'h01, 3'(f), 7'h33), 1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, malu);
    end
    for (int i = 0; i < 6; i++)
      add(32'h0000_707F, enc(7'h00, b_f3[i], 7'h63), 0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, b_alu[i]);
    add(32'h0000_007F, 32'h0000_006F, 0, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 4'd0);
    add(32'h0000_707F, 32'h0000_0067, 0, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 4'd0);
    add(32'h0000_007F, 32'h0000_0037, 0, 1'b1, 3'd4, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    add(32'h0000_007F, 32'h0000_0017, 0, 1'b1, 3'd4, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  function automatic void lookup(input logic [31:0] ins, input bit en_m, output bit found, output exp_t e);
    found = 1'b0;
    e = '0;
    foreach (tbl[i]) begin
      if (!found && ((ins & tbl[i].mask) == tbl[i].match) && (!tbl[i].needs_m || en_m)) begin
        found = 1'b1;
        e = tbl[i].e;
        e.valid = 1'b1;
      end
    end
  endfunction

  task automatic check_regs(input int k);
    chk($sformatf("valid_e[%0d]", k), valid_e[k], st_e[k].valid);
    chk($sformatf("branch_e[%0d]", k), branch_e[k], st_e[k].branch);
    chk($sformatf("branchop_e[%0d]", k), branchop_e[k], st_e[k].branchop);
    chk($sformatf("jump_e[%0d]", k), jump_e[k], st_e[k].jump);
    chk($sformatf("jumpreg_e[%0d]", k), jumpreg_e[k], st_e[k].jumpreg);
    if (!st_e[k].dc_src) begin
      chk($sformatf("alucontrol_e[%0d]", k), alucontrol_e[k], st_e[k].alucontrol);
      chk($sformatf("alusrca_e[%0d]", k), alusrca_e[k], st_e[k].alusrca);
      chk($sformatf("alusrcb_e[%0d]", k), alusrcb_e[k], st_e[k].alusrcb);
    end
    chk($sformatf("valid_m[%0d]", k), valid_m[k], st_m[k].valid);
    chk($sformatf("memwrite_m[%0d]", k), memwrite_m[k], st_m[k].memwrite);
    chk($sformatf("memsize_m[%0d]", k), memsize_m[k], st_m[k].memsize);
    chk($sformatf("regwrite_m[%0d]", k), regwrite_m[k], st_m[k].regwrite);
    chk($sformatf("valid_w[%0d]", k), valid_w[k], st_w[k].valid);
    chk($sformatf("resultsrc_w[%0d]", k), resultsrc_w[k], st_w[k].resultsrc);
    chk($sformatf("regwrite_w[%0d]", k), regwrite_w[k], st_w[k].regwrite);
  endtask

  // One cycle: drive D, check decode outputs, advance the model, clock, check E/M/W.
  task automatic cyc(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    bit   f;
    exp_t e;
    exp_t d;
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      lookup(ins, (k == 1), f, e);
      chk($sformatf("illegal_d[%0d] instr=%08h", k, ins), illegal_d[k], (k == 0) ? (v && !f) : 1'b0);
      if (f && !e.dc_imm) chk($sformatf("immsrc_d[%0d] instr=%08h", k, ins), immsrc_d[k], e.immsrc);
      d = (v && f) ? e : '0;
      st_w[k] = st_m[k];
      st_m[k] = (st && !fl) ? '0 : st_e[k];
      st_e[k] = fl ? '0 : (st ? st_e[k] : d);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_regs(k);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_memwrite_m", memwrite_m[0], 1'b0);
    chk("rst_async_valid_m", valid_m[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      st_e[k] = '0; st_m[k] = '0; st_w[k] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_regs(k);
  endtask

  initial begin
    logic [31:0] ins;
    int          r;
    int          j;
    clk = 1'b0; reset = 1'b1;
    instr_d = 32'h0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_e[k] = '0; st_m[k] = '0; st_w[k] = '0;
    end
    build_table();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) check_regs(k);

    // lw / add / jalr back to back
    cyc(I_LW, 1'b1, 1'b0, 1'b0);   chk("jr_lw", jumpreg_e[0], 1'b0);
    cyc(I_ADD, 1'b1, 1'b0, 1'b0);  chk("jr_add", jumpreg_e[0], 1'b0);
    cyc(I_JALR, 1'b1, 1'b0, 1'b0); chk("jr_jalr", jumpreg_e[0], 1'b1);
    chk("rs_w_lw", resultsrc_w[0], 2'b01);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  chk("rs_w_add", resultsrc_w[0], 2'b00);
    chk("rw_w_add", regwrite_w[0], 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  chk("rs_w_jalr", resultsrc_w[0], 2'b10);

    // two-cycle stall on add
    cyc(I_ADD, 1'b1, 1'b0, 1'b0);
    rw_pulses = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(I_LW, 1'b1, 1'b1, 1'b0);
      chk("stall_valid_m", valid_m[0], 1'b0);
      chk("stall_valid_e", valid_e[0], 1'b1);
      chk("stall_alu_e", alucontrol_e[0], 4'b0000);
      chk("stall_srcb_e", alusrcb_e[0], 1'b0);
      rw_pulses += int'(regwrite_w[0]);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(32'h0, 1'b0, 1'b0, 1'b0);
      rw_pulses += int'(regwrite_w[0]);
    end
    chk("stall_rw_pulses", rw_pulses, 1);

    // flush and stall together on a beq held in E
    cyc(I_BEQ, 1'b1, 1'b0, 1'b0);  chk("beq_branch_e", branch_e[0], 1'b1);
    cyc(32'h0, 1'b0, 1'b1, 1'b1);
    chk("fs_branch_e", branch_e[0], 1'b0);
    chk("fs_valid_e", valid_e[0], 1'b0);

    // illegal encodings and RV32M
    cyc(32'h0, 1'b1, 1'b0, 1'b0);
    chk("zero_illegal0", illegal_d[0], 1'b1);
    chk("zero_illegal1", illegal_d[1], 1'b0);
    chk("zero_valid_e", valid_e[0], 1'b0);
    cyc(I_MUL, 1'b1, 1'b0, 1'b0);
    chk("mul_illegal0", illegal_d[0], 1'b1);
    chk("mul_valid_e0", valid_e[0], 1'b0);
    chk("mul_alu_e1", alucontrol_e[1], 4'b1100);
    chk("mul_valid_e1", valid_e[1], 1'b1);

    // auipc / lui / bltu
    cyc(I_AUIPC, 1'b1, 1'b0, 1'b0);
    chk("auipc_srca", alusrca_e[0], 2'b01);
    chk("auipc_imm", immsrc_d[0], 3'b100);
    cyc(I_LUI, 1'b1, 1'b0, 1'b0);   chk("lui_srca", alusrca_e[0], 2'b10);
    cyc(I_BLTU, 1'b1, 1'b0, 1'b0);
    chk("bltu_alu", alucontrol_e[0], 4'b0110);
    chk("bltu_bop", branchop_e[0], 3'b110);

    // reset with a store in M
    cyc(I_SW, 1'b1, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);   chk("sw_memwrite_m", memwrite_m[0], 1'b1);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        j = $urandom_range(0, tbl.size() - 1);
        ins = ($urandom & ~tbl[j].mask) | tbl[j].match;
      end else if (r < 95) begin
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 8)];
      end else begin
        ins = (r < 97) ? 32'h0 : $urandom;
      end
      cyc(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
      if (n == 700) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
